// File: rtl/mul_seq_responder.sv
// -----------------------------------------------------------------------------
// mul_seq_responder
//
// Iterative unsigned multiplier behind a pair of valid/ready channels. A tagged
// operand pair is accepted in IDLE. The product is built radix-2^BPC over
// WIDTH/BPC CALC iterations, plus one closing CALC cycle that registers the
// result. The low WIDTH bits of the product are returned together with the
// request tag in RESP. Only one request is in flight at a time. Latency is
// fixed: there is no early exit on zero operands.
//
// Parameters:
//   WIDTH  operand/result width (default 64)
//   BPC    multiplier bits consumed per CALC cycle; must divide WIDTH
//   TAG_W  tag width
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset, priority over all handshakes
//   req_valid   request valid            req_ready   responder idle, can accept
//   req_a/req_b unsigned operands        req_tag     tag echoed on response
//   rsp_valid   response valid           rsp_ready   initiator accepts response
//   rsp_result  (a*b) mod 2^WIDTH        rsp_tag     tag of answered request
//   busy        high in CALC or RESP
//
// Optional build macro MUL_SEQ_DPI_CHECK_EN:
//   Adds a simulation-only cross-check against a reference 64-bit product.
//   The reference is computed when a request is accepted. It is compared
//   with rsp_result on every response handshake. This requires WIDTH=64.
//   Cycle behaviour is the same with or without the macro.
// -----------------------------------------------------------------------------
module mul_seq_responder #(
    parameter int WIDTH = 64,
    parameter int BPC   = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int ITERS = WIDTH / BPC;
    localparam int CNT_W = $clog2(ITERS + 1);

    generate
        if ((WIDTH % BPC) != 0) begin : g_bad_bpc
            $error("mul_seq_responder: BPC must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [TAG_W-1:0] rsp_tag_reg, rsp_tag_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // The multiplicand register is shifted left by BPC each iteration.
    // So a_reg is always already aligned to the weight of the current
    // multiplier digit, which is b_reg[BPC-1:0].
    logic [WIDTH-1:0] pp_terms [BPC];
    logic [WIDTH-1:0] partial;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
            assign pp_terms[gi] = b_reg[gi] ? (a_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        partial = '0;
        for (int i = 0; i < BPC; i++) begin
            partial = partial + pp_terms[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            result_reg  <= '0;
            tag_reg     <= '0;
            rsp_tag_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            acc_reg     <= acc_next;
            result_reg  <= result_next;
            tag_reg     <= tag_next;
            rsp_tag_reg <= rsp_tag_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        acc_next     = acc_reg;
        result_next  = result_reg;
        tag_next     = tag_reg;
        rsp_tag_next = rsp_tag_reg;
        cnt_next     = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    a_next     = req_a;
                    b_next     = req_b;
                    tag_next   = req_tag;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                // After the last iteration, one more cycle registers the
                // result. This is what sets the fixed 17-edge latency.
                if (cnt_reg == CNT_W'(ITERS)) begin
                    result_next  = acc_reg;
                    rsp_tag_next = tag_reg;
                    state_next   = RESP;
                end else begin
                    acc_next = acc_reg + partial;
                    a_next   = a_reg << BPC;
                    b_next   = b_reg >> BPC;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready  = (state_reg == IDLE);
    assign rsp_valid  = (state_reg == RESP);
    assign busy       = (state_reg != IDLE);
    assign rsp_result = result_reg;
    assign rsp_tag    = rsp_tag_reg;

`ifdef MUL_SEQ_DPI_CHECK_EN
    generate
        if (WIDTH != 64) begin : g_bad_dpi_width
            $fatal(1, "mul_seq_responder: DPI check requires WIDTH=64");
        end
    endgenerate

    logic [63:0] dpi_exp_reg;
    logic [63:0] dpi_a_reg;
    logic [63:0] dpi_b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            dpi_exp_reg <= '0;
            dpi_a_reg   <= '0;
            dpi_b_reg   <= '0;
        end else begin
            if (req_valid && req_ready) begin
                dpi_exp_reg <= 64'(req_a) * 64'(req_b);
                dpi_a_reg   <= 64'(req_a);
                dpi_b_reg   <= 64'(req_b);
            end
            if (rsp_valid && rsp_ready && (64'(rsp_result) != dpi_exp_reg)) begin
                $error("mul_seq_responder: tag=%h a=%h b=%h expected=%h got=%h",
                       rsp_tag, dpi_a_reg, dpi_b_reg, dpi_exp_reg, rsp_result);
            end
        end
    end
`else
    // Default build: the design is pure RTL. The reference cross-check is not
    // compiled in.
`endif

endmodule

// File: tb/tb_mul_seq_responder.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_responder
//
// Self-checking bench for mul_seq_responder using the default parameters.
// Expected products come from plain 64-bit arithmetic on the recorded
// operands. A queue holds accepted requests in order, and every response is
// matched against the head of that queue. The bench prints one line per
// response transaction and ends with one summary line.
// -----------------------------------------------------------------------------
module tb_mul_seq_responder;

    localparam int WIDTH = 64;
    localparam int TAG_W = 8;
    localparam int LAT   = 17;
    localparam int NRAND = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    mul_seq_responder #(.WIDTH(WIDTH), .BPC(4), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
        int               acc_edge;
    } req_t;

    req_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   n_rsp      = 0;
    bit   prev_rsp_valid = 1'b0;
    bit   last_req_fire  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle. Before the edge, the task checks the current outputs
    // against the model and records which handshakes the coming edge will
    // complete. Then it advances to #1 after the edge.
    task automatic tick();
        req_t        head;
        logic [63:0] prod;
        bit          req_fire;
        bit          rsp_fire;
        req_fire = req_valid && req_ready && !rst;
        rsp_fire = rsp_valid && rsp_ready && !rst;
        if (!rst) begin
            check("req_ready_idle", {63'b0, req_ready}, {63'b0, q.size() == 0});
            check("busy_inflight", {63'b0, busy}, {63'b0, q.size() != 0});
            if (rsp_valid && !prev_rsp_valid) begin
                if (q.size() == 0) check("spurious_rsp", {63'b0, rsp_valid}, 64'd0);
                else check("latency", 64'(cyc - q[0].acc_edge), 64'(LAT));
            end
            if (rsp_fire && q.size() != 0) begin
                head = q.pop_front();
                prod = head.a * head.b;
                check("result", rsp_result, prod);
                check("tag", 64'(rsp_tag), 64'(head.tag));
                n_rsp++;
                $display("rsp %0d: tag=%h a=%h b=%h result=%h", n_rsp, rsp_tag, head.a, head.b, rsp_result);
            end
            if (req_fire) q.push_back('{a: req_a, b: req_b, tag: req_tag, acc_edge: cyc + 1});
        end else begin
            q.delete();
        end
        last_req_fire  = req_fire;
        prev_rsp_valid = rsp_valid;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag);
        int n;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_tag = tag;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_req_fire && n < 100);
        check("accept_timeout", {63'b0, last_req_fire}, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 40 && !rsp_valid; i++) tick();
        check("rsp_timeout", {63'b0, rsp_valid}, 64'd1);
    endtask

    initial begin
        int guard;
        int issued;
        rst = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_tag = '0;
        rsp_ready = 1'b1;

        // Reset then idle
        tick();
        tick();
        check("rst_req_ready", {63'b0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_result", rsp_result, 64'd0);
        check("rst_tag", 64'(rsp_tag), 64'd0);
        rst = 1'b0;
        tick();

        // Basic request
        send(64'd6, 64'd7, 8'h5A);
        wait_rsp();
        check("basic_result", rsp_result, 64'd42);
        check("basic_tag", 64'(rsp_tag), 64'h5A);
        tick();
        check("basic_one_cycle", {63'b0, rsp_valid}, 64'd0);

        // Overflow
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h11);
        wait_rsp();
        check("ovf1_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        send(64'h1_0000_0000, 64'h1_0000_0000, 8'h12);
        wait_rsp();
        check("ovf2_result", rsp_result, 64'd0);
        tick();

        // Backpressure, with a competing request that must not be accepted
        rsp_ready = 1'b0;
        send(64'd3, 64'd5, 8'hB5);
        wait_rsp();
        req_valid = 1'b1;
        req_a = 64'd100;
        req_b = 64'd100;
        req_tag = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", {63'b0, rsp_valid}, 64'd1);
            check("bp_result", rsp_result, 64'd15);
            check("bp_tag", 64'(rsp_tag), 64'hB5);
            check("bp_req_ready", {63'b0, req_ready}, 64'd0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_released", {63'b0, rsp_valid}, 64'd0);
        check("bp_ready_after", {63'b0, req_ready}, 64'd1);

        // Reset in the middle of CALC
        send(64'd9, 64'd9, 8'h99);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_req_ready", {63'b0, req_ready}, 64'd1);
        check("midrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        for (int i = 0; i < 30; i++) tick();
        send(64'd1, 64'd1, 8'h01);
        wait_rsp();
        check("midrst_next", rsp_result, 64'd1);
        tick();

        // Randomised back-to-back traffic with random response backpressure
        issued = 0;
        guard = 0;
        while ((issued < NRAND || q.size() != 0 || req_valid) && guard < 60000) begin
            if (!req_valid && issued < NRAND) begin
                req_valid = 1'b1;
                case ($urandom_range(0, 7))
                    0: req_a = '0;
                    1: req_a = '1;
                    default: req_a = {$urandom, $urandom};
                endcase
                case ($urandom_range(0, 7))
                    0: req_b = '0;
                    1: req_b = '1;
                    2: req_b = 64'($urandom_range(0, 255));
                    default: req_b = {$urandom, $urandom};
                endcase
                req_tag = issued[TAG_W-1:0];
                issued++;
            end
            rsp_ready = ($urandom_range(0, 1) == 1);
            tick();
            if (last_req_fire) req_valid = 1'b0;
            guard++;
        end
        check("random_drain", 64'(q.size()), 64'd0);
        check("random_issued", 64'(issued), 64'(NRAND));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
